// File: rtl/double_to_unsigned_int_if.sv
// Operand/result bundle for the binary64 -> unsigned integer converter.
// Optional flags signal is present only when DOUBLE_TO_UINT_FLAGS_EN is defined.
interface double_to_unsigned_int_if #(
  parameter int OUT_WIDTH = 64
);
  logic                 in_valid;
  logic [63:0]          a;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] z;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
  logic [1:0]           flags;

  modport master (output in_valid, output a, input out_valid, input z, input flags);
  modport slave  (input in_valid, input a, output out_valid, output z, output flags);
`else
  modport master (output in_valid, output a, input out_valid, input z);
  modport slave  (input in_valid, input a, output out_valid, output z);
`endif
endinterface

// File: rtl/double_to_unsigned_int.sv
// Three-stage binary64 -> unsigned integer converter (truncate toward zero,
// saturating). Stage 1 unpacks/classifies, stage 2 shifts, stage 3 selects the
// saturated or shifted result and registers it.
// Optional macro DOUBLE_TO_UINT_FLAGS_EN adds the {invalid, inexact} flags.
module double_to_unsigned_int #(
  parameter int OUT_WIDTH = 64
) (
  input logic                     clk,
  input logic                     rst_n,
  double_to_unsigned_int_if.slave bus
);
  localparam logic [1:0]  CLS_ZERO = 2'd0;  // zero or denormal
  localparam logic [1:0]  CLS_NAN  = 2'd1;
  localparam logic [1:0]  CLS_INF  = 2'd2;
  localparam logic [1:0]  CLS_NORM = 2'd3;
  localparam logic [10:0] EXP_MAX  = 11'h7FF;
  localparam logic [10:0] EXP_ONE  = 11'd1023;
  localparam logic [10:0] EXP_SAT  = 11'(1023 + OUT_WIDTH);

  logic [10:0] exp_s;
  assign exp_s = bus.a[62:52];

  // Stage 1 state
  logic        s1_valid_d, s1_valid_q;
  logic        s1_sign_d, s1_sign_q;
  logic [1:0]  s1_cls_d, s1_cls_q;
  logic        s1_neg_d, s1_neg_q;    // unbiased exponent < 0
  logic        s1_big_d, s1_big_q;    // unbiased exponent >= OUT_WIDTH
  logic [52:0] s1_mant_d, s1_mant_q;
  logic [5:0]  s1_shamt_d, s1_shamt_q;
  // Stage 2 state
  logic                 s2_valid_d, s2_valid_q;
  logic                 s2_sign_d, s2_sign_q;
  logic [1:0]           s2_cls_d, s2_cls_q;
  logic                 s2_neg_d, s2_neg_q;
  logic                 s2_big_d, s2_big_q;
  logic [OUT_WIDTH-1:0] s2_int_d, s2_int_q;
  // Stage 3 (output) state
  logic                 out_valid_d, out_valid_q;
  logic [OUT_WIDTH-1:0] z_d, z_q;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
  logic         s1_frac_nz_d, s1_frac_nz_q;
  logic         s2_frac_nz_d, s2_frac_nz_q;
  logic         s2_inexact_d, s2_inexact_q;
  logic [1:0]   flags_d, flags_q;
  logic [116:0] work_s;   // full working value, fraction bits kept for inexact
`else
  logic [116:52] work_s;  // only the integer part of the working value is needed
`endif

  // Stage 1: unpack the operand and classify it.
  // The shift amount is the unbiased exponent modulo 64: (exp - 1023) mod 64 == exp[5:0] + 1.
  always_comb begin
    s1_valid_d = bus.in_valid;
    s1_sign_d  = bus.a[63];
    s1_mant_d  = {1'b1, bus.a[51:0]};
    s1_shamt_d = bus.a[57:52] + 6'd1;
    s1_neg_d   = (exp_s < EXP_ONE);
    s1_big_d   = (exp_s >= EXP_SAT);
    if (exp_s == 11'd0) begin
      s1_cls_d = CLS_ZERO;
    end else if (exp_s == EXP_MAX) begin
      if (bus.a[51:0] != 52'd0) begin
        s1_cls_d = CLS_NAN;
      end else begin
        s1_cls_d = CLS_INF;
      end
    end else begin
      s1_cls_d = CLS_NORM;
    end
`ifdef DOUBLE_TO_UINT_FLAGS_EN
    s1_frac_nz_d = |bus.a[51:0];
`endif
  end

  // Stage 2: single left barrel shift of the 117-bit working value; the binary
  // point sits between bits 52 and 51, so the integer part is work_s[116:52].
  always_comb begin
`ifdef DOUBLE_TO_UINT_FLAGS_EN
    work_s       = {64'd0, s1_mant_q} << s1_shamt_q;
    s2_inexact_d = |work_s[51:0];
    s2_frac_nz_d = s1_frac_nz_q;
`else
    work_s       = 65'(({64'd0, s1_mant_q} << s1_shamt_q) >> 7'd52);
`endif
    s2_valid_d = s1_valid_q;
    s2_sign_d  = s1_sign_q;
    s2_cls_d   = s1_cls_q;
    s2_neg_d   = s1_neg_q;
    s2_int_d   = work_s[52 +: OUT_WIDTH];
    // Any integer bit above OUT_WIDTH on a non-negative exponent is an overflow.
    s2_big_d   = s1_big_q | (~s1_neg_q & (|work_s[116:52+OUT_WIDTH]));
  end

  // Stage 3: saturate/select in priority order; hold z (and flags) when idle.
  always_comb begin
    out_valid_d = s2_valid_q;
    z_d         = z_q;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
    flags_d     = flags_q;
`endif
    if (s2_valid_q) begin
      if (s2_cls_q == CLS_NAN) begin
        z_d = {OUT_WIDTH{1'b0}};
`ifdef DOUBLE_TO_UINT_FLAGS_EN
        flags_d = 2'b10;
`endif
      end else if (s2_sign_q && ((s2_cls_q == CLS_INF) || ((s2_cls_q == CLS_NORM) && !s2_neg_q))) begin
        z_d = {OUT_WIDTH{1'b0}};
`ifdef DOUBLE_TO_UINT_FLAGS_EN
        flags_d = 2'b10;
`endif
      end else if (!s2_sign_q && ((s2_cls_q == CLS_INF) || ((s2_cls_q == CLS_NORM) && s2_big_q))) begin
        z_d = {OUT_WIDTH{1'b1}};
`ifdef DOUBLE_TO_UINT_FLAGS_EN
        flags_d = 2'b10;
`endif
      end else if (s2_cls_q == CLS_ZERO) begin
        z_d = {OUT_WIDTH{1'b0}};
`ifdef DOUBLE_TO_UINT_FLAGS_EN
        flags_d = {1'b0, s2_frac_nz_q};
`endif
      end else if (s2_neg_q) begin
        z_d = {OUT_WIDTH{1'b0}};
`ifdef DOUBLE_TO_UINT_FLAGS_EN
        flags_d = 2'b01;
`endif
      end else begin
        z_d = s2_int_q;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
        flags_d = {1'b0, s2_inexact_q};
`endif
      end
    end else begin
      z_d = z_q;
    end
  end

  // Pipeline registers with synchronous active-low reset clearing every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= CLS_ZERO;
      s1_neg_q    <= 1'b0;
      s1_big_q    <= 1'b0;
      s1_mant_q   <= 53'd0;
      s1_shamt_q  <= 6'd0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= CLS_ZERO;
      s2_neg_q    <= 1'b0;
      s2_big_q    <= 1'b0;
      s2_int_q    <= {OUT_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      z_q         <= {OUT_WIDTH{1'b0}};
`ifdef DOUBLE_TO_UINT_FLAGS_EN
      s1_frac_nz_q <= 1'b0;
      s2_frac_nz_q <= 1'b0;
      s2_inexact_q <= 1'b0;
      flags_q      <= 2'b00;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_q    <= s1_cls_d;
      s1_neg_q    <= s1_neg_d;
      s1_big_q    <= s1_big_d;
      s1_mant_q   <= s1_mant_d;
      s1_shamt_q  <= s1_shamt_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_neg_q    <= s2_neg_d;
      s2_big_q    <= s2_big_d;
      s2_int_q    <= s2_int_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
      s1_frac_nz_q <= s1_frac_nz_d;
      s2_frac_nz_q <= s2_frac_nz_d;
      s2_inexact_q <= s2_inexact_d;
      flags_q      <= flags_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
`ifdef DOUBLE_TO_UINT_FLAGS_EN
  assign bus.flags     = flags_q;
`endif
endmodule

// File: tb/tb_double_to_unsigned_int.sv
// Scoreboard bench for double_to_unsigned_int: one 64-bit and one 32-bit
// instance share the same operand stream; expected results are queued on drive
// and popped when out_valid appears. Flags are checked only when
// DOUBLE_TO_UINT_FLAGS_EN is defined.
module tb_double_to_unsigned_int;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        drv_valid;
  logic [63:0] drv_a;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [63:0] z;
    logic [1:0]  f;
    int          due;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];

  double_to_unsigned_int_if #(.OUT_WIDTH(64)) bus64 ();
  double_to_unsigned_int_if #(.OUT_WIDTH(32)) bus32 ();

  assign bus64.in_valid = drv_valid;
  assign bus64.a        = drv_a;
  assign bus32.in_valid = drv_valid;
  assign bus32.a        = drv_a;

  double_to_unsigned_int #(.OUT_WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));
  double_to_unsigned_int #(.OUT_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endfunction

  // Independent reference: right shift with remainder mask for e<=52, left shift above.
  function automatic void ref_model(input logic [63:0] a, input int w,
                                    output logic [63:0] z, output logic [1:0] f);
    logic        s;
    logic [10:0] ex;
    logic [51:0] fr;
    logic [63:0] m;
    logic [63:0] ones;
    int          e;
    s    = a[63];
    ex   = a[62:52];
    fr   = a[51:0];
    ones = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    z    = 64'd0;
    f    = 2'b00;
    e    = int'(ex) - 1023;
    if (ex == 11'h7FF) begin
      if (fr != 52'd0 || s) f = 2'b10;
      else begin z = ones; f = 2'b10; end
    end else if (ex == 11'd0) begin
      f = {1'b0, fr != 52'd0};
    end else if (e < 0) begin
      f = 2'b01;
    end else if (s) begin
      f = 2'b10;
    end else if (e >= w) begin
      z = ones;
      f = 2'b10;
    end else begin
      m = {11'd0, 1'b1, fr};
      if (e <= 52) begin
        z = m >> (52 - e);
        f = {1'b0, (m & ((64'd1 << (52 - e)) - 64'd1)) != 64'd0};
      end else begin
        z = m << (e - 52);
      end
    end
  endfunction

  task automatic send(input logic [63:0] av, input logic push,
                      input logic [63:0] z64, input logic [1:0] f64,
                      input logic [63:0] z32, input logic [1:0] f32);
    @(negedge clk);
    drv_valid = 1'b1;
    drv_a     = av;
    if (push) begin
      q64.push_back('{z: z64, f: f64, due: cyc + 3});
      q32.push_back('{z: z32, f: f32, due: cyc + 3});
    end
  endtask

  task automatic send_model(input logic [63:0] av);
    logic [63:0] z64, z32;
    logic [1:0]  f64, f32;
    ref_model(av, 64, z64, f64);
    ref_model(av, 32, z32, f32);
    send(av, 1'b1, z64, f64, z32, f32);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drv_valid = 1'b0;
    end
  endtask

  // Output monitor for the 64-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus64.out_valid === 1'b1) begin
      chk("sb64_expected", 64'(q64.size() != 0), 64'd1);
      if (q64.size() != 0) begin
        e = q64.pop_front();
        chk("lat64", 64'(cyc), 64'(e.due));
        chk("z64", bus64.z, e.z);
`ifdef DOUBLE_TO_UINT_FLAGS_EN
        chk("flags64", {62'd0, bus64.flags}, {62'd0, e.f});
`endif
      end
    end
  end

  // Output monitor for the 32-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus32.out_valid === 1'b1) begin
      chk("sb32_expected", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("lat32", 64'(cyc), 64'(e.due));
        chk("z32", {32'd0, bus32.z}, e.z);
`ifdef DOUBLE_TO_UINT_FLAGS_EN
        chk("flags32", {62'd0, bus32.flags}, {62'd0, e.f});
`endif
      end
    end
  end

  initial begin
    logic [63:0] r;
    logic [10:0] ex;
    rst_n     = 1'b0;
    drv_valid = 1'b1;
    drv_a     = 64'h3FF0_0000_0000_0000;
    repeat (3) @(negedge clk);
    chk("rst_valid64", {63'd0, bus64.out_valid}, 64'd0);
    chk("rst_z64", bus64.z, 64'd0);
    chk("rst_valid32", {63'd0, bus32.out_valid}, 64'd0);
    chk("rst_z32", {32'd0, bus32.z}, 64'd0);
    drv_valid = 1'b0;
    rst_n     = 1'b1;

    // Directed: operand, z64, flags64, z32, flags32
    send(64'h3FF0_0000_0000_0000, 1'b1, 64'd1, 2'b00, 64'd1, 2'b00);                                    // 1.0
    send(64'h4006_0000_0000_0000, 1'b1, 64'd2, 2'b01, 64'd2, 2'b01);                                    // 2.75
    send(64'h3FE0_0000_0000_0000, 1'b1, 64'd0, 2'b01, 64'd0, 2'b01);                                    // 0.5
    send(64'h43E0_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 2'b00, 64'hFFFF_FFFF, 2'b10);          // 2^63
    send(64'h43F0_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'hFFFF_FFFF, 2'b10);          // 2^64
    send(64'hBFF0_0000_0000_0000, 1'b1, 64'd0, 2'b10, 64'd0, 2'b10);                                    // -1.0
    send(64'h7FF8_0000_0000_0000, 1'b1, 64'd0, 2'b10, 64'd0, 2'b10);                                    // NaN
    send(64'h8000_0000_0000_0000, 1'b1, 64'd0, 2'b00, 64'd0, 2'b00);                                    // -0.0
    send(64'h41EF_FFFF_FFE0_0000, 1'b1, 64'hFFFF_FFFF, 2'b00, 64'hFFFF_FFFF, 2'b00);                    // 2^32-1
    send(64'h41F0_0000_0000_0000, 1'b1, 64'h1_0000_0000, 2'b00, 64'hFFFF_FFFF, 2'b10);                  // 2^32
    send(64'h0000_0000_0000_0001, 1'b1, 64'd0, 2'b01, 64'd0, 2'b01);                                    // denormal
    send(64'h7FF0_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'hFFFF_FFFF, 2'b10);          // +inf
    send(64'hFFF0_0000_0000_0000, 1'b1, 64'd0, 2'b10, 64'd0, 2'b10);                                    // -inf
    send(64'hBFE0_0000_0000_0000, 1'b1, 64'd0, 2'b01, 64'd0, 2'b01);                                    // -0.5
    send(64'h43EF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_F800, 2'b00, 64'hFFFF_FFFF, 2'b10);          // largest < 2^64
    send(64'h3FF8_0000_0000_0000, 1'b1, 64'd1, 2'b01, 64'd1, 2'b01);                                    // 1.5
    idle(2);

    // Random back-to-back operands, exponents weighted toward the interesting range.
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom};
      case (i % 8)
        0: ex = 11'($urandom_range(0, 2047));
        1: ex = (r[0]) ? 11'h7FF : 11'd0;
        default: ex = 11'($urandom_range(1010, 1090));
      endcase
      if (i % 5 == 0) r[29:0] = 30'd0;
      r[62:52] = ex;
      send_model(r);
    end
    idle(4);

    // Reset with two operands in flight plus one offered during reset: none may emerge.
    send(64'h4000_0000_0000_0000, 1'b0, 64'd0, 2'b00, 64'd0, 2'b00);
    send(64'h4008_0000_0000_0000, 1'b0, 64'd0, 2'b00, 64'd0, 2'b00);
    @(negedge clk);
    rst_n     = 1'b0;
    drv_valid = 1'b1;
    drv_a     = 64'h4010_0000_0000_0000;
    @(negedge clk);
    rst_n     = 1'b1;
    drv_valid = 1'b0;
    chk("midrst_valid64", {63'd0, bus64.out_valid}, 64'd0);
    chk("midrst_z64", bus64.z, 64'd0);
    chk("midrst_z32", {32'd0, bus32.z}, 64'd0);
    send(64'h4014_0000_0000_0000, 1'b1, 64'd5, 2'b00, 64'd5, 2'b00);                                    // 5.0
    idle(8);

    chk("drain64", 64'(q64.size()), 64'd0);
    chk("drain32", 64'(q32.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
